// File: rtl/compress_pkg.sv
// Shared types and helpers for the code compressor.
package compress_pkg;

  typedef enum logic [1:0] {
    EMPTY,  // nothing pending
    CAND,   // pending word matches a dictionary entry, waiting for its twin
    FORCE   // pending word has no match and must be flushed
  } state_e;

  // Output words below this value are tokens; literals here are ambiguous.
  localparam logic [31:0] TOKEN_LIMIT    = 32'h10;
  localparam logic [3:0]  TOKEN_BASE_DEF = 4'hA;

  // Zero-extend a 4-bit token code into a full output word.
  function automatic logic [31:0] token_word(input logic [3:0] code);
    return {28'h0, code};
  endfunction

endpackage

// File: rtl/compress_dict.sv
// Dictionary register file with a priority-encoded parallel compare.
module compress_dict #(
  parameter int NUM_TOKENS = 3,
  parameter int IDX_W      = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we_i,
  input  logic [IDX_W-1:0] widx_i,
  input  logic [31:0]      wdata_i,
  input  logic [31:0]      cmp_i,
  output logic             hit_o,
  output logic [IDX_W-1:0] idx_o
);

  logic [NUM_TOKENS-1:0][31:0] entry_q;
  logic [NUM_TOKENS-1:0]       vld_q;

  // Entry storage; a write marks the entry valid. Out-of-range indices hit nothing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entry_q <= '0;
      vld_q   <= '0;
    end else if (we_i) begin
      for (int i = 0; i < NUM_TOKENS; i++) begin
        if (widx_i == IDX_W'(i)) begin
          entry_q[i] <= wdata_i;
          vld_q[i]   <= 1'b1;
        end
      end
    end
  end

  // Compare against every valid entry; scanning high to low lets the lowest index win.
  always_comb begin
    hit_o = 1'b0;
    idx_o = '0;
    for (int i = NUM_TOKENS - 1; i >= 0; i--) begin
      if (vld_q[i] && entry_q[i] == cmp_i) begin
        hit_o = 1'b1;
        idx_o = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/code_compressor.sv
// Streaming compressor: identical back-to-back dictionary hits collapse to one token word.
module code_compressor
  import compress_pkg::*;
#(
  parameter int         NUM_TOKENS = 3,
  parameter logic [3:0] TOKEN_BASE = TOKEN_BASE_DEF,
  parameter int         CNT_W      = 16,
  localparam int        IDX_W      = (NUM_TOKENS > 1) ? $clog2(NUM_TOKENS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we_i,
  input  logic [IDX_W-1:0] cfg_idx_i,
  input  logic [31:0]      cfg_instr_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [31:0]      in_data_i,
  input  logic             in_last_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [31:0]      out_data_o,
  output logic             out_last_o,
  input  logic             stat_clr_i,
  output logic [CNT_W-1:0] in_count_o,
  output logic [CNT_W-1:0] out_count_o,
  output logic             err_literal_o
);

  state_e             state_q, state_d;
  logic [31:0]        pend_q, pend_d;
  logic [IDX_W-1:0]   k_q, k_d;
  logic               last_q, last_d;
  logic               out_valid_q, out_valid_d;
  logic [31:0]        out_data_q, out_data_d;
  logic               out_last_q, out_last_d;
  logic [CNT_W-1:0]   in_cnt_q, out_cnt_q;
  logic               err_q;

  logic               slot, acc, cfg_ok, hit;
  logic [IDX_W-1:0]   hit_idx;
  logic               emit, emit_last;
  logic [31:0]        emit_data;

  // Output register may take a new word when empty or being drained this cycle.
  assign slot       = !out_valid_q || out_ready_i;
  // A lone candidate that closed its program is flushed before new input is taken.
  assign in_ready_o = slot && (state_q == EMPTY || (state_q == CAND && !last_q));
  assign acc        = in_valid_i && in_ready_o;
  // Dictionary is only rewritten when the pipeline is completely idle.
  assign cfg_ok     = cfg_we_i && state_q == EMPTY && !out_valid_q;

  compress_dict #(.NUM_TOKENS(NUM_TOKENS), .IDX_W(IDX_W)) u_dict (
    .clk    (clk),
    .rst    (rst),
    .we_i   (cfg_ok),
    .widx_i (cfg_idx_i),
    .wdata_i(cfg_instr_i),
    .cmp_i  (in_data_i),
    .hit_o  (hit),
    .idx_o  (hit_idx)
  );

  // Next-state and emit decision for the pending-word FSM.
  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    k_d       = k_q;
    last_d    = last_q;
    emit      = 1'b0;
    emit_data = '0;
    emit_last = 1'b0;
    unique case (state_q)
      EMPTY: if (acc) begin
        if (hit) begin
          state_d = CAND;
          pend_d  = in_data_i;
          k_d     = hit_idx;
          last_d  = in_last_i;
        end else begin
          emit      = 1'b1;
          emit_data = in_data_i;
          emit_last = in_last_i;
        end
      end
      CAND: if (last_q) begin
        if (slot) begin
          emit      = 1'b1;
          emit_data = pend_q;
          emit_last = 1'b1;
          state_d   = EMPTY;
        end
      end else if (acc) begin
        if (in_data_i == pend_q) begin
          emit      = 1'b1;
          emit_data = token_word(TOKEN_BASE + 4'(k_q));
          emit_last = in_last_i;
          state_d   = EMPTY;
        end else begin
          emit      = 1'b1;
          emit_data = pend_q;
          pend_d    = in_data_i;
          last_d    = in_last_i;
          k_d       = hit_idx;
          state_d   = hit ? CAND : FORCE;
        end
      end
      FORCE: if (slot) begin
        emit      = 1'b1;
        emit_data = pend_q;
        emit_last = last_q;
        state_d   = EMPTY;
      end
      default: state_d = EMPTY;
    endcase
  end

  // Output register holds steady under backpressure; reloads only through a free slot.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    if (slot) begin
      out_valid_d = emit;
      if (emit) begin
        out_data_d = emit_data;
        out_last_d = emit_last;
      end
    end
  end

  // FSM, pending word and output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= EMPTY;
      pend_q      <= '0;
      k_q         <= '0;
      last_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      k_q         <= k_d;
      last_q      <= last_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

  // Saturating statistics and sticky ambiguous-literal flag; clear beats increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      err_q     <= 1'b0;
    end else if (stat_clr_i) begin
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      if (acc && in_cnt_q != '1)                   in_cnt_q  <= in_cnt_q + 1'b1;
      if (out_valid_q && out_ready_i && out_cnt_q != '1) out_cnt_q <= out_cnt_q + 1'b1;
      if (acc && in_data_i < TOKEN_LIMIT)          err_q     <= 1'b1;
    end
  end

  assign out_valid_o   = out_valid_q;
  assign out_data_o    = out_data_q;
  assign out_last_o    = out_last_q;
  assign in_count_o    = in_cnt_q;
  assign out_count_o   = out_cnt_q;
  assign err_literal_o = err_q;

endmodule

// File: tb/tb_code_compressor.sv
// Randomized bench for code_compressor against a greedy-pairing reference model.
module tb_code_compressor;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_we;
  logic [1:0]  cfg_idx;
  logic [31:0] cfg_instr;
  logic        in_valid, in_ready, in_last;
  logic [31:0] in_data;
  logic        out_valid, out_ready, out_last;
  logic [31:0] out_data;
  logic        stat_clr;
  logic [15:0] in_count, out_count;
  logic        err_lit;

  int n_vec = 0;
  int n_err = 0;

  // reference state
  logic [31:0] dd[3];
  bit          dv[3];
  logic [31:0] stim_d[$];
  bit          stim_l[$];
  logic [32:0] exp_q[$];
  logic [32:0] got_q[$];
  int          exp_in, exp_out, last_stalls;

  code_compressor dut (
    .clk(clk), .rst(rst),
    .cfg_we_i(cfg_we), .cfg_idx_i(cfg_idx), .cfg_instr_i(cfg_instr),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data), .in_last_i(in_last),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data), .out_last_o(out_last),
    .stat_clr_i(stat_clr), .in_count_o(in_count), .out_count_o(out_count), .err_literal_o(err_lit)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int lookup(input logic [31:0] w);
    for (int i = 0; i < 3; i++) if (dv[i] && dd[i] == w) return i;
    return -1;
  endfunction

  // Greedy pairing per program: a dictionary word immediately repeated (not across last) becomes a token.
  function automatic void build_exp();
    int i, k, n;
    exp_q.delete();
    n = stim_d.size();
    i = 0;
    while (i < n) begin
      k = lookup(stim_d[i]);
      if (k >= 0 && !stim_l[i] && i + 1 < n && stim_d[i+1] == stim_d[i]) begin
        exp_q.push_back({stim_l[i+1], 28'h0, 4'(4'hA + k)});
        i += 2;
      end else begin
        exp_q.push_back({stim_l[i], stim_d[i]});
        i += 1;
      end
    end
  endfunction

  task automatic add(input logic [31:0] d, input bit l);
    stim_d.push_back(d);
    stim_l.push_back(l);
  endtask

  task automatic cfg(input int idx, input logic [31:0] w);
    @(negedge clk);
    cfg_we = 1'b1; cfg_idx = 2'(idx); cfg_instr = w;
    @(negedge clk);
    cfg_we = 1'b0;
    dd[idx] = w; dv[idx] = 1'b1;
  endtask

  task automatic clr();
    @(negedge clk);
    stat_clr = 1'b1;
    @(negedge clk);
    stat_clr = 1'b0;
    exp_in = 0; exp_out = 0;
  endtask

  // mode 0: always ready, 1: random valid/ready, 2: ready held low for cycles 4..9
  task automatic run(input int mode, input string tag);
    int ip, cyc, n;
    logic [31:0] snap_d;
    logic        snap_l;
    build_exp();
    got_q.delete();
    n = stim_d.size();
    ip = 0; cyc = 0; last_stalls = 0; snap_d = '0; snap_l = 1'b0;
    while (!(ip == n && got_q.size() >= exp_q.size()) && cyc < 4000) begin
      @(negedge clk);
      in_valid  = (ip < n) && (mode != 1 || $urandom_range(0, 3) != 0);
      in_data   = (ip < n) ? stim_d[ip] : 32'h0;
      in_last   = (ip < n) ? stim_l[ip] : 1'b0;
      out_ready = (mode == 1) ? ($urandom_range(0, 3) != 0) :
                  (mode == 2) ? !(cyc >= 4 && cyc < 10) : 1'b1;
      #1;
      if (mode == 2 && cyc == 4) begin
        snap_d = out_data; snap_l = out_last;
        chk({tag, "_bp_vld"}, 64'(out_valid), 64'd1);
      end
      if (mode == 2 && cyc > 4 && cyc < 10) begin
        chk({tag, "_bp_data"}, 64'(out_data), 64'(snap_d));
        chk({tag, "_bp_last"}, 64'(out_last), 64'(snap_l));
        chk({tag, "_bp_rdy"}, 64'(in_ready), 64'd0);
      end
      if (in_valid && in_ready) ip++;
      else if (in_valid && out_ready) last_stalls++;
      if (out_valid && out_ready) got_q.push_back({out_last, out_data});
      @(posedge clk);
      cyc++;
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    chk({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      chk({tag, "_word"}, (i < got_q.size()) ? 64'(got_q[i]) : 64'hDEAD, 64'(exp_q[i]));
    exp_in  += n;
    exp_out += exp_q.size();
    chk({tag, "_in_cnt"}, 64'(in_count), 64'(exp_in));
    chk({tag, "_out_cnt"}, 64'(out_count), 64'(exp_out));
    stim_d.delete(); stim_l.delete();
  endtask

  task automatic rand_progs(input int progs);
    logic [31:0] alpha[4];
    logic [31:0] w;
    int len;
    alpha[0] = 32'h11111111; alpha[1] = 32'h22222222;
    alpha[2] = 32'h33333333; alpha[3] = 32'h44444444;
    w = alpha[0];
    for (int p = 0; p < progs; p++) begin
      len = $urandom_range(1, 8);
      for (int j = 0; j < len; j++) begin
        if ($urandom_range(0, 1) == 0) w = alpha[$urandom_range(0, 3)];
        add(w, j == len - 1);
      end
    end
  endtask

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_idx = '0; cfg_instr = '0;
    in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1; stat_clr = 1'b0;
    for (int i = 0; i < 3; i++) begin dd[i] = '0; dv[i] = 1'b0; end
    exp_in = 0; exp_out = 0;
    repeat (2) @(negedge clk);
    chk("rst_vld", 64'(out_valid), 64'd0);
    chk("rst_data", 64'(out_data), 64'd0);
    chk("rst_last", 64'(out_last), 64'd0);
    chk("rst_cnt", 64'({in_count, out_count}), 64'd0);
    chk("rst_err", 64'(err_lit), 64'd0);
    rst = 1'b0;

    // pair match
    cfg(0, 32'h00A00093);
    clr();
    add(32'h00A00093, 0); add(32'h00A00093, 0); add(32'h00000013, 1);
    run(0, "pair");
    if (got_q.size() > 0) chk("pair_tok", 64'(got_q[0]), 64'h0000000A);

    // lone candidate forced out, one cycle of in_ready low
    cfg(1, 32'h00100113);
    add(32'h00100113, 0); add(32'h00208093, 1); add(32'h00000013, 1);
    run(0, "lone");
    chk("lone_stall", 64'(last_stalls), 64'd1);

    // odd/even run
    cfg(2, 32'h00000033);
    for (int i = 0; i < 5; i++) add(32'h00000033, i == 4);
    run(0, "run5");

    // backpressure window
    for (int i = 0; i < 12; i++) add(32'h80000000 | $urandom, i == 11);
    run(2, "bp");

    // ambiguous literal
    add(32'h00000005, 1);
    run(0, "lit");
    chk("lit_err", 64'(err_lit), 64'd1);
    clr();
    #1 chk("lit_clr", 64'({err_lit, in_count}), 64'd0);

    // config write while in CAND must be ignored
    @(negedge clk);
    in_valid = 1'b1; in_data = 32'h00100113; in_last = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    cfg_we = 1'b1; cfg_idx = 2'd1; cfg_instr = 32'h12345678;
    @(negedge clk);
    cfg_we = 1'b0;
    in_valid = 1'b1; in_data = 32'h00100113; in_last = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    #1 chk("cand_tok", 64'({out_valid, out_last, out_data}), {32'h0, 2'b11, 32'h0000000B});
    clr();
    add(32'h12345678, 0); add(32'h12345678, 1); add(32'h00100113, 0); add(32'h00100113, 1);
    run(0, "cfgign");

    // reset mid-stream while a candidate is pending
    @(negedge clk);
    in_valid = 1'b1; in_data = 32'h00000013; in_last = 1'b0;
    @(negedge clk);
    in_data = 32'h00A00093;
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    rst = 1'b1;
    #1;
    chk("mrst_vld", 64'(out_valid), 64'd0);
    chk("mrst_cnt", 64'({in_count, out_count}), 64'd0);
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) dv[i] = 1'b0;
    exp_in = 0; exp_out = 0;
    add(32'h00A00093, 0); add(32'h00A00093, 1);
    run(0, "postrst");

    // random programs, duplicate entry checks lowest-index priority
    cfg(0, 32'h11111111); cfg(1, 32'h22222222); cfg(2, 32'h11111111);
    clr();
    rand_progs(25);
    run(1, "rnd1");
    cfg(2, 32'h33333333);
    rand_progs(25);
    run(1, "rnd2");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
